symbol_deserializer: RTL

Receive-side counterpart of the transmit symbol serializer. Collects 2-bit QPSK symbols strobed by the demodulator into a 128-bit cipher block, MSB-first, and presents completed blocks to the decryption core over a valid/ready handshake. A one-block holding register lets symbol collection continue while the consumer stalls. A symbol-gap timeout discards stalled partial blocks.

---
 rtl/zmodem_pkg.sv | 8 +
 rtl/symbol_deserializer.sv | 74 +++++++
 2 files changed

// File: rtl/zmodem_pkg.sv
// zmodem_pkg: block/symbol geometry and FSM state types shared by the symbol serializer and deserializer
package zmodem_pkg;
    localparam int BLOCK_W        = 128;
    localparam int SYM_W          = 2;
    localparam int SYMS_PER_BLOCK = BLOCK_W / SYM_W;
    typedef enum logic {IDLE, COLLECT} collect_state_t;
    typedef enum logic {EMPTY, FULL} out_state_t;
endpackage

// File: rtl/symbol_deserializer.sv
// symbol_deserializer: packs strobed QPSK symbols MSB-first into cipher blocks behind a one-block hold register
module symbol_deserializer #(
    parameter int BLOCK_W        = zmodem_pkg::BLOCK_W,
    parameter int SYM_W          = zmodem_pkg::SYM_W,
    parameter int TIMEOUT_CYCLES = 400
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SYM_W-1:0]   symbol_data,
    input  logic               symbol_valid,
    input  logic               frame_sync,
    output logic [BLOCK_W-1:0] cipher_data,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               overflow,
    output logic               timeout_err,
    output logic [5:0]         sym_count
);
    import zmodem_pkg::*;
    localparam int SPB = BLOCK_W / SYM_W;
    localparam logic [5:0] LAST = 6'(SPB - 1);
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    collect_state_t     cs_q, cs_d;
    out_state_t         os_q, os_d;
    logic [BLOCK_W-1:0] shift_q, shift_d, hold_q, hold_d, block;
    logic [5:0]         cnt_q, cnt_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               ovf_q, ovf_d, tmo_q, tmo_d;
    logic               sym_done, accept, gap_hit, load;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q    <= IDLE;
            os_q    <= EMPTY;
            shift_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            cs_q    <= cs_d;
            os_q    <= os_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end
    // frame_sync always restarts the count, so it can never coincide with a completion
    always_comb begin
        block    = {shift_q[BLOCK_W-SYM_W-1:0], symbol_data};
        sym_done = symbol_valid && !frame_sync && cnt_q == LAST;
        accept   = os_q == FULL && data_ready;
        gap_hit  = cs_q == COLLECT && !symbol_valid && !frame_sync && gap_q == GW'(TIMEOUT_CYCLES - 1);
        load     = sym_done && (os_q == EMPTY || accept);
        shift_d  = symbol_valid ? block : shift_q;
        cnt_d    = frame_sync ? {5'd0, symbol_valid} :
                   (sym_done || gap_hit) ? 6'd0 :
                   symbol_valid ? cnt_q + 6'd1 : cnt_q;
        cs_d     = cnt_d == 6'd0 ? IDLE : COLLECT;
        gap_d    = (symbol_valid || frame_sync || cs_q == IDLE || gap_hit) ? '0 : gap_q + GW'(1);
        os_d     = sym_done ? FULL : accept ? EMPTY : os_q;
        hold_d   = load ? block : hold_q;
        ovf_d    = sym_done && os_q == FULL && !data_ready;
        tmo_d    = gap_hit;
    end
    assign cipher_data = hold_q;
    assign data_valid  = os_q == FULL;
    assign overflow    = ovf_q;
    assign timeout_err = tmo_q;
    assign sym_count   = cnt_q;
endmodule
